// File: rtl/block_pack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | block_pack_pkg : shared types and lane-mask helper for block_pack         |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
package block_pack_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    TAIL = 1'b1
  } pack_state_t;

  // Upper bound on lanes the mask helper covers; ELMS must stay below this.
  localparam int c_max_lanes = 32;

  function automatic logic [c_max_lanes-1:0] mask_lanes(input int unsigned cnt);
    logic [c_max_lanes-1:0] m;
    m = '0;
    for (int i = 0; i < c_max_lanes; i++) begin
      m[i] = (i < cnt);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | block_shift : lane-granular shifter/rotator over an ELMS-lane vector      |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module block_shift #(
  parameter int ELMS     = 16,
  parameter int DATA     = 8,
  parameter int AMTW     = $clog2(ELMS),
  parameter bit ROTATE   = 1'b0,
  parameter bit TO_RIGHT = 1'b0
) (
  input  logic [ELMS-1:0][DATA-1:0] din,
  input  logic [AMTW-1:0]           amt,
  output logic [ELMS-1:0][DATA-1:0] dout
);

  always_comb begin
    int d;
    d    = 0;
    dout = '0;
    for (int i = 0; i < ELMS; i++) begin
      for (int j = 0; j < ELMS; j++) begin
        // d is where source lane j lands; lanes pushed off the end vanish unless rotating
        d = TO_RIGHT ? (j - int'(amt)) : (j + int'(amt));
        if (ROTATE) begin
          d = ((d % ELMS) + ELMS) % ELMS;
        end
        if (d == i) begin
          dout[i] = din[j];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/block_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | block_pack : packs variable-occupancy beats gap-free into full words      |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module block_pack
  import block_pack_pkg::*;
#(
  parameter int ELMS = 8,
  parameter int DATA = 8,
  parameter int CNTW = $clog2(ELMS+1)
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ELMS-1:0][DATA-1:0] in_data,
  input  logic [CNTW-1:0]           in_cnt,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ELMS-1:0][DATA-1:0] out_data,
  output logic [CNTW-1:0]           out_cnt,
  output logic                      out_last,
  output logic [CNTW-1:0]           fill
);

  localparam logic [CNTW-1:0] c_elms     = CNTW'(ELMS);
  localparam logic [CNTW:0]   c_elms_tot = (CNTW+1)'(ELMS);

  pack_state_t                 r_state, w_state_nxt;
  logic [CNTW-1:0]             r_fill, w_fill_nxt;
  logic [ELMS-1:0][DATA-1:0]   r_res, w_res_nxt;
  logic                        r_out_valid, w_out_valid_nxt;
  logic [ELMS-1:0][DATA-1:0]   r_out_data, w_out_data_nxt;
  logic [CNTW-1:0]             r_out_cnt, w_out_cnt_nxt;
  logic                        r_out_last, w_out_last_nxt;

  logic [CNTW-1:0]             w_cnt_sat;
  logic [CNTW:0]               w_tot;
  logic [c_max_lanes-1:0]      w_mask;
  logic                        w_unused_mask;
  logic [2*ELMS-1:0][DATA-1:0] w_shift_in, w_shifted, w_comb;
  logic                        w_slot_free, w_accept;

  assign w_cnt_sat     = (in_cnt > c_elms) ? c_elms : in_cnt;
  assign w_mask        = mask_lanes(32'(w_cnt_sat));
  assign w_unused_mask = ^w_mask[c_max_lanes-1:ELMS];
  assign w_tot         = {1'b0, r_fill} + {1'b0, w_cnt_sat};

  // Residue lanes at and above fill are always zero, so OR-merge is enough.
  for (genvar i = 0; i < 2*ELMS; i++) begin : g_lane
    if (i < ELMS) begin : g_low
      assign w_shift_in[i] = w_mask[i] ? in_data[i] : '0;
      assign w_comb[i]     = w_shifted[i] | r_res[i];
    end else begin : g_high
      assign w_shift_in[i] = '0;
      assign w_comb[i]     = w_shifted[i];
    end
  end

  block_shift #(
    .ELMS     (2*ELMS),
    .DATA     (DATA),
    .AMTW     (CNTW),
    .ROTATE   (1'b0),
    .TO_RIGHT (1'b0)
  ) u_shift (
    .din  (w_shift_in),
    .amt  (r_fill),
    .dout (w_shifted)
  );

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == ACC) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_fill_nxt      = r_fill;
    w_res_nxt       = r_res;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_cnt_nxt   = r_out_cnt;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      ACC: begin
        if (w_accept) begin
          if (w_tot < c_elms_tot) begin
            if (!in_last) begin
              w_res_nxt  = w_comb[ELMS-1:0];
              w_fill_nxt = CNTW'(w_tot);
            end else begin
              w_out_valid_nxt = 1'b1;
              w_out_data_nxt  = w_comb[ELMS-1:0];
              w_out_cnt_nxt   = CNTW'(w_tot);
              w_out_last_nxt  = 1'b1;
              w_res_nxt       = '0;
              w_fill_nxt      = '0;
            end
          end else begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_comb[ELMS-1:0];
            w_out_cnt_nxt   = c_elms;
            w_out_last_nxt  = in_last && (w_tot == c_elms_tot);
            w_res_nxt       = w_comb[2*ELMS-1:ELMS];
            w_fill_nxt      = CNTW'(w_tot - c_elms_tot);
            // A last beat that spills past one word needs an extra flush cycle.
            if (in_last && (w_tot != c_elms_tot)) begin
              w_state_nxt = TAIL;
            end
          end
        end
      end
      TAIL: begin
        if (w_slot_free) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = r_res;
          w_out_cnt_nxt   = r_fill;
          w_out_last_nxt  = 1'b1;
          w_res_nxt       = '0;
          w_fill_nxt      = '0;
          w_state_nxt     = ACC;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_fill      <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_fill      <= w_fill_nxt;
      r_res       <= w_res_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;
  assign out_last  = r_out_last;
  assign fill      = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_block_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_block_pack : directed and randomized bench for block_pack              |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_block_pack;

  localparam int ELMS = 8;
  localparam int DATA = 8;
  localparam int CNTW = 4;

  typedef struct {
    logic [ELMS*DATA-1:0] data;
    int                   cnt;
    bit                   last;
  } word_t;

  logic                      clk;
  logic                      reset_;
  logic                      in_valid;
  logic                      in_ready;
  logic [ELMS-1:0][DATA-1:0] in_data;
  logic [CNTW-1:0]           in_cnt;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready_w;
  logic [ELMS-1:0][DATA-1:0] out_data;
  logic [CNTW-1:0]           out_cnt;
  logic                      out_last;
  logic [CNTW-1:0]           fill;

  logic rand_mode, rand_bit, fixed_ready;
  int   checks, failures;

  logic [DATA-1:0] frame_q[$];
  word_t           exp_q[$];
  word_t           act_q[$];

  assign out_ready_w = rand_mode ? rand_bit : fixed_ready;

  block_pack #(.ELMS(ELMS), .DATA(DATA)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready_w),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_last  (out_last),
    .fill      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) rand_bit = ($urandom_range(0, 3) != 0);

  always @(posedge clk) begin
    if (reset_ && out_valid && out_ready_w) begin
      word_t w;
      w.data = out_data;
      w.cnt  = int'(out_cnt);
      w.last = out_last;
      act_q.push_back(w);
    end
  end

  function automatic logic [ELMS*DATA-1:0] mk_beat(input int first, input int n);
    logic [ELMS*DATA-1:0] v;
    for (int k = 0; k < ELMS; k++) v[k*DATA +: DATA] = (k < n) ? DATA'(first + k) : 8'hA5;
    return v;
  endfunction

  function automatic logic [ELMS*DATA-1:0] mk_word(input int first, input int n);
    logic [ELMS*DATA-1:0] v;
    for (int k = 0; k < ELMS; k++) v[k*DATA +: DATA] = (k < n) ? DATA'(first + k) : '0;
    return v;
  endfunction

  // Reference: a frame's elements are chopped into ELMS-sized words in order.
  function automatic void model_accept(input int cnt, input logic [ELMS*DATA-1:0] d, input bit last);
    int sat, n, idx;
    word_t w;
    sat = (cnt > ELMS) ? ELMS : cnt;
    for (int k = 0; k < sat; k++) frame_q.push_back(d[k*DATA +: DATA]);
    if (!last) return;
    n = frame_q.size();
    idx = 0;
    while (n - idx >= ELMS) begin
      w.data = '0;
      for (int k = 0; k < ELMS; k++) w.data[k*DATA +: DATA] = frame_q[idx + k];
      w.cnt = ELMS;
      w.last = 1'b0;
      exp_q.push_back(w);
      idx += ELMS;
    end
    if (idx < n) begin
      w.data = '0;
      for (int k = 0; k < n - idx; k++) w.data[k*DATA +: DATA] = frame_q[idx + k];
      w.cnt = n - idx;
      w.last = 1'b1;
      exp_q.push_back(w);
    end else if (sat == 0) begin
      w.data = '0;
      w.cnt = 0;
      w.last = 1'b1;
      exp_q.push_back(w);
    end else begin
      exp_q[exp_q.size()-1].last = 1'b1;
    end
    frame_q.delete();
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send_beat(input int cnt, input logic [ELMS*DATA-1:0] d, input bit last);
    int guard;
    in_valid = 1'b1;
    in_cnt   = CNTW'(cnt);
    in_data  = d;
    in_last  = last;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
      in_valid = 1'b0;
      @(negedge clk);
      return;
    end
    model_accept(cnt, d, last);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    #2;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    if (out_data !== '0)    begin failures++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    if (out_cnt !== '0)     begin failures++; $display("FAIL rst_out_cnt: got %0d want 0", out_cnt); end
    if (out_last !== 1'b0)  begin failures++; $display("FAIL rst_out_last: got %0b want 0", out_last); end
    if (fill !== '0)        begin failures++; $display("FAIL rst_fill: got %0d want 0", fill); end
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    fixed_ready = 1'b0;
    send_beat(3, mk_beat(100, 3), 1'b0);
    send_beat(8, mk_beat(103, 8), 1'b0);
    in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_midrst_valid: got %0b want 1", out_valid); end
    if (fill !== 4'd3)      begin failures++; $display("FAIL pre_midrst_fill: got %0d want 3", fill); end
    #2;
    reset_ = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
    if (fill !== '0)        begin failures++; $display("FAIL midrst_fill: got %0d want 0", fill); end
    frame_q.delete();
    exp_q.delete();
    act_q.delete();
    fixed_ready = 1'b1;
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pack();
    send_beat(5, mk_beat(1, 5), 1'b0);
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_early_valid: got %0b want 0", out_valid); end
    if (fill !== 4'd5)      begin failures++; $display("FAIL pack_fill5: got %0d want 5", fill); end
    send_beat(5, mk_beat(6, 5), 1'b0);
    checks += 5;
    if (out_valid !== 1'b1)          begin failures++; $display("FAIL pack_w1_valid: got %0b want 1", out_valid); end
    if (out_data !== mk_word(1, 8))  begin failures++; $display("FAIL pack_w1_data: got %h want %h", out_data, mk_word(1, 8)); end
    if (out_cnt !== 4'd8)            begin failures++; $display("FAIL pack_w1_cnt: got %0d want 8", out_cnt); end
    if (out_last !== 1'b0)           begin failures++; $display("FAIL pack_w1_last: got %0b want 0", out_last); end
    if (fill !== 4'd2)               begin failures++; $display("FAIL pack_fill2: got %0d want 2", fill); end
    send_beat(3, mk_beat(11, 3), 1'b1);
    in_valid = 1'b0;
    checks += 5;
    if (out_valid !== 1'b1)          begin failures++; $display("FAIL pack_w2_valid: got %0b want 1", out_valid); end
    if (out_data !== mk_word(9, 5))  begin failures++; $display("FAIL pack_w2_data: got %h want %h", out_data, mk_word(9, 5)); end
    if (out_cnt !== 4'd5)            begin failures++; $display("FAIL pack_w2_cnt: got %0d want 5", out_cnt); end
    if (out_last !== 1'b1)           begin failures++; $display("FAIL pack_w2_last: got %0b want 1", out_last); end
    if (fill !== '0)                 begin failures++; $display("FAIL pack_fill0: got %0d want 0", fill); end
    @(negedge clk);
  endtask

  task automatic test_tail();
    send_beat(6, mk_beat(21, 6), 1'b0);
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL tail_pre_valid: got %0b want 0", out_valid); end
    if (fill !== 4'd6)      begin failures++; $display("FAIL tail_fill6: got %0d want 6", fill); end
    send_beat(4, mk_beat(27, 4), 1'b1);
    in_valid = 1'b0;
    checks += 5;
    if (out_data !== mk_word(21, 8)) begin failures++; $display("FAIL tail_full_data: got %h want %h", out_data, mk_word(21, 8)); end
    if (out_cnt !== 4'd8)            begin failures++; $display("FAIL tail_full_cnt: got %0d want 8", out_cnt); end
    if (out_last !== 1'b0)           begin failures++; $display("FAIL tail_full_last: got %0b want 0", out_last); end
    if (in_ready !== 1'b0)           begin failures++; $display("FAIL tail_in_ready: got %0b want 0", in_ready); end
    if (fill !== 4'd2)               begin failures++; $display("FAIL tail_fill2: got %0d want 2", fill); end
    @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b1)          begin failures++; $display("FAIL tail_w_valid: got %0b want 1", out_valid); end
    if (out_data !== mk_word(29, 2)) begin failures++; $display("FAIL tail_w_data: got %h want %h", out_data, mk_word(29, 2)); end
    if (out_cnt !== 4'd2)            begin failures++; $display("FAIL tail_w_cnt: got %0d want 2", out_cnt); end
    if (out_last !== 1'b1)           begin failures++; $display("FAIL tail_w_last: got %0b want 1", out_last); end
    if (in_ready !== 1'b1)           begin failures++; $display("FAIL tail_ready_back: got %0b want 1", in_ready); end
    if (fill !== '0)                 begin failures++; $display("FAIL tail_fill0: got %0d want 0", fill); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n0;
    fixed_ready = 1'b0;
    send_beat(8, mk_beat(40, 8), 1'b0);
    n0 = act_q.size();
    in_valid = 1'b1;
    in_cnt   = 4'd8;
    in_data  = mk_beat(48, 8);
    in_last  = 1'b1;
    repeat (4) begin
      #1;
      checks += 3;
      if (in_ready !== 1'b0)           begin failures++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
      if (out_valid !== 1'b1)          begin failures++; $display("FAIL bp_valid_held: got %0b want 1", out_valid); end
      if (out_data !== mk_word(40, 8)) begin failures++; $display("FAIL bp_data_stable: got %h want %h", out_data, mk_word(40, 8)); end
      @(negedge clk);
    end
    fixed_ready = 1'b1;
    send_beat(8, mk_beat(48, 8), 1'b1);
    in_valid = 1'b0;
    checks += 2;
    if (out_data !== mk_word(48, 8)) begin failures++; $display("FAIL bp_next_data: got %h want %h", out_data, mk_word(48, 8)); end
    if (out_last !== 1'b1)           begin failures++; $display("FAIL bp_next_last: got %0b want 1", out_last); end
    @(negedge clk);
    checks += 2;
    if (act_q.size() != n0 + 2) begin failures++; $display("FAIL bp_transfers: got %0d want %0d", act_q.size(), n0 + 2); end
    if (out_valid !== 1'b0)     begin failures++; $display("FAIL bp_valid_drop: got %0b want 0", out_valid); end
  endtask

  task automatic test_zero_last();
    send_beat(0, mk_beat(0, 0), 1'b1);
    in_valid = 1'b0;
    checks += 4;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid: got %0b want 1", out_valid); end
    if (out_cnt !== '0)     begin failures++; $display("FAIL zero_cnt: got %0d want 0", out_cnt); end
    if (out_last !== 1'b1)  begin failures++; $display("FAIL zero_last: got %0b want 1", out_last); end
    if (out_data !== '0)    begin failures++; $display("FAIL zero_data: got %h want 0", out_data); end
    @(negedge clk);
  endtask

  task automatic test_soak();
    int cnt, guard, n;
    bit last;
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, ELMS));
      last = ($urandom_range(0, 5) == 0) || (i == 399);
      send_beat(cnt, {$urandom, $urandom}, last);
      if (!last) begin
        checks++;
        if (int'(fill) != frame_q.size() % ELMS) begin
          failures++;
          $display("FAIL soak_fill: got %0d want %0d", fill, frame_q.size() % ELMS);
        end
      end
    end
    in_valid = 1'b0;
    rand_mode = 1'b0;
    fixed_ready = 1'b1;
    guard = 0;
    while (act_q.size() < exp_q.size() && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL soak_word_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (act_q[k].data !== exp_q[k].data || act_q[k].cnt != exp_q[k].cnt || act_q[k].last != exp_q[k].last) begin
        failures++;
        $display("FAIL soak_word[%0d]: got %h cnt=%0d last=%0b want %h cnt=%0d last=%0b",
                 k, act_q[k].data, act_q[k].cnt, act_q[k].last, exp_q[k].data, exp_q[k].cnt, exp_q[k].last);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rand_mode   = 1'b0;
    rand_bit    = 1'b1;
    fixed_ready = 1'b1;
    in_valid    = 1'b0;
    in_cnt      = '0;
    in_data     = '0;
    in_last     = 1'b0;
    reset_      = 1'b0;
    test_reset();
    test_pack();
    test_tail();
    test_backpressure();
    test_zero_last();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
